// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-unit state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_BLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_exec_unit_seq_multiplier.sv
// Radix-2 shift-add multiplier: one partial product per step, WIDTH steps per product.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state of the datapath; product is the accumulator including this step's partial product.
    always_comb begin
        acc_s    = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = {WIDTH{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
        end else if (step) begin
            acc_d    = acc_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end else begin
            acc_d    = acc_q;
        end
    end

    assign done    = step && (cnt_q == CNT_W'(WIDTH - 1));
    assign product = acc_s;

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus an iterative multiply that stalls upstream.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUCtl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             Zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_s;
    logic             mul_start_s;
    logic             mul_step_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_product_s;

    seq_multiplier #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start_s),
        .step    (mul_step_s),
        .a       (A),
        .b       (B),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Single-cycle ALU; unknown codes (and mul, handled elsewhere) give zero.
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (ALUCtl)
            ALU_AND: alu_s = A & B;
            ALU_OR:  alu_s = A | B;
            ALU_ADD: alu_s = A + B;
            ALU_SUB: alu_s = A - B;
            ALU_BLT: alu_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: alu_s = {WIDTH{1'b0}};
        endcase
    end

    // FSM next-state and output register loads; flush beats both accept and mul completion.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        mul_start_s = 1'b0;
        mul_step_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (in_valid && (ALUCtl == ALU_MUL)) begin
                    mul_start_s = 1'b1;
                    state_d     = MUL;
                end else if (in_valid) begin
                    result_d    = alu_s;
                    zero_d      = (alu_s == {WIDTH{1'b0}});
                    out_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    mul_step_s = 1'b1;
                    if (mul_done_s) begin
                        state_d     = IDLE;
                        result_d    = mul_product_s;
                        zero_d      = (mul_product_s == {WIDTH{1'b0}});
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUCtl;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic [31:0] result;
    logic        Zero;

    int tests_run;
    int tests_failed;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUCtl    (ALUCtl),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .result    (result),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a single-cycle op and check its result one cycle later.
    task automatic single_op(input string tag, input logic [3:0] ctl,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic exp_zero);
        in_valid = 1'b1;
        ALUCtl   = ctl;
        A        = a;
        B        = b;
        tick();
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_zero"}, {31'd0, Zero}, {31'd0, exp_zero});
    endtask

    // Issue a mul, hold junk on the inputs while busy, and check stall and final result.
    task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_zero);
        in_valid = 1'b1;
        ALUCtl   = 4'b1000;
        A        = a;
        B        = b;
        tick();
        ALUCtl = 4'b0010;
        A      = 32'h1234_5678;
        B      = 32'h0000_0001;
        for (int k = 1; k <= 32; k++) begin
            check_eq({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
            check_eq({tag, "_busy_valid"}, {31'd0, out_valid}, 32'd0);
            if (k == 32) in_valid = 1'b0;
            tick();
        end
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_zero"}, {31'd0, Zero}, {31'd0, exp_zero});
        check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        check_eq({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int pulses;
        tests_run    = 0;
        tests_failed = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        ALUCtl   = 4'b0000;
        A        = 32'd0;
        B        = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_zero", {31'd0, Zero}, 32'd1);

        // Back-to-back single-cycle ops.
        single_op("add", 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0);
        single_op("sub", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
        single_op("blt", 4'b0111, 32'd5, 32'd7, 32'd1, 1'b0);
        single_op("sub_eq", 4'b0110, 32'd7, 32'd7, 32'd0, 1'b1);
        single_op("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
        single_op("or", 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
        single_op("blt_neg", 4'b0111, 32'h8000_0000, 32'd1, 32'd1, 1'b0);
        single_op("blt_ge", 4'b0111, 32'd1, 32'h8000_0000, 32'd0, 1'b1);
        in_valid = 1'b0;
        tick();
        check_eq("idle_valid", {31'd0, out_valid}, 32'd0);
        check_eq("idle_hold", result, 32'd0);

        mul_op("mul", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0);
        mul_op("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
        mul_op("mul_zero", 32'd12345, 32'd0, 32'd0, 1'b1);

        // Flush a mul at t+10; the concurrent in_valid is dropped.
        single_op("pre_flush", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0);
        ALUCtl = 4'b1000;
        A      = 32'd3;
        B      = 32'd4;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        ALUCtl   = 4'b0010;
        A        = 32'd100;
        B        = 32'd100;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_ready", {31'd0, in_ready}, 32'd1);
        check_eq("flush_hold", result, 32'd2);
        single_op("post_flush", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0);
        flush = 1'b1;
        ALUCtl = 4'b0010;
        A      = 32'd4;
        B      = 32'd4;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_drop_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_drop_hold", result, 32'd5);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (out_valid) pulses++;
        end
        check_eq("flush_no_late", pulses, 32'd0);

        // Reset in the middle of a mul.
        single_op("pre_rst", 4'b0010, 32'd9, 32'd9, 32'd18, 1'b0);
        ALUCtl = 4'b1000;
        A      = 32'd3;
        B      = 32'd4;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mrst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("mrst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mrst_result", result, 32'd0);
        check_eq("mrst_zero", {31'd0, Zero}, 32'd1);
        pulses = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (out_valid) pulses++;
        end
        check_eq("mrst_no_late", pulses, 32'd0);

        single_op("pre_unk", 4'b0010, 32'd9, 32'd9, 32'd18, 1'b0);
        single_op("unk", 4'b0011, 32'd9, 32'd9, 32'd0, 1'b1);
        single_op("unk_f", 4'b1111, 32'd9, 32'd9, 32'd0, 1'b1);
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALUCtl code from the ALU control decoder together with two operands, and produces a registered result and a Zero flag.
- and, or, add, sub and blt complete in one cycle.
- mul uses an iterative radix-2 shift-add multiplier over WIDTH cycles. During that time the unit deasserts in_ready so the pipeline stalls upstream.
- Output feeds the EX/MEM register and the branch logic.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, $clog2(WIDTH), width of the multiply iteration counter. Derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of any in-flight operation (branch mispredict/trap)
- in_valid  input  1  operands and ALUCtl valid this cycle
- in_ready  output  1  unit can accept an operation this cycle
- ALUCtl  input  4  operation code: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 blt, 1000 mul
- A  input  WIDTH  operand 1 (rs1)
- B  input  WIDTH  operand 2 (rs2 or immediate)
- out_valid  output  1  single-cycle pulse: result and Zero valid
- result  output  WIDTH  registered result
- Zero  output  1  registered (result == 0)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, Zero=1. Counter, multiplicand and accumulator registers are cleared.
- Accept rule: an operation is accepted when in_valid && in_ready. in_ready is 1 exactly when state==IDLE. Inputs are ignored in all other cycles.
- State machine has two states, IDLE and MUL.
- IDLE, accept of a non-mul code:
  - result is computed combinationally and registered at this edge.
  - out_valid=1 in the next cycle. Latency is 1. State stays IDLE.
- IDLE, accept of mul:
  - Latch multiplicand=A, multiplier=B, accumulator=0, counter=0. Go to MUL.
- MUL, each cycle:
  - If multiplier[0] is set, accumulator += multiplicand. All arithmetic is mod 2^WIDTH.
  - multiplicand shifts left by 1, multiplier shifts right by 1, counter increments.
  - On the cycle with counter==WIDTH-1: load result with the final accumulator, then return to IDLE.
  - out_valid=1 in the following cycle. Latency is WIDTH+1 cycles from the accept cycle.
  - in_ready=0 for WIDTH cycles.
- Mul returns the low WIDTH bits of the product, so signed and unsigned give identical results.
- Arithmetic rules:
  - add and sub wrap modulo 2^WIDTH. No overflow flag.
  - blt: result = {WIDTH-1 zeros, ($signed(A) < $signed(B))}.
  - Any other code (e.g. 0011, 1111) yields result=0 with latency 1. It is not an error.
- Zero is registered in the same edge as result, as (next result == 0).
- result and Zero hold their values until the next completion. out_valid is a one-cycle pulse. There is no downstream backpressure.
- Back-to-back operations:
  - In the out_valid cycle of a mul, state is IDLE and a new operation may be accepted.
  - Consecutive single-cycle operations give one out_valid per cycle.
- flush:
  - Forces state=IDLE and suppresses out_valid for the killed operation in the next cycle.
  - result and Zero are left unchanged.
  - An in_valid arriving in the same cycle as flush is dropped.
  - flush takes priority over accept and over MUL completion.
- reset mid-MUL: aborts the operation, restores all reset values, and produces no out_valid. reset has priority over flush.
- Operand changes on A and B during MUL have no effect, because the operands are latched.

Decomposition:
- Shared package alu_pkg holds:
  - the ALUCtl localparams: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_BLT=4'b0111, ALU_MUL=4'b1000;
  - the state encoding: IDLE, MUL.
- The ALU control decoder imports the same constants.
- One sub-module, seq_multiplier, holds the shift-add datapath and counter. It has start/done and operand/product ports.
- The top level holds the single-cycle ALU, the FSM and the output registers.

Test Plan:
- add, sub and blt: A=5, B=7 with ALUCtl=0010, 0110, 0111 on three consecutive cycles -> out_valid on three consecutive cycles. Results are 12 (Zero=0), 0xFFFFFFFE (Zero=0), 1 (Zero=0). Then A=7, B=7 sub -> result=0, Zero=1.
- and/or: A=0xF0F0F0F0, B=0x0FF00FF0. and -> 0x00F000F0; or -> 0xFFF0FFF0. blt with A=0x80000000, B=1 -> 1 (signed compare).
- mul: A=0x0000FFFF, B=0x00010001, accepted at cycle t.
  - in_ready=0 for cycles t+1..t+32.
  - out_valid only at t+33, with result=0xFFFFFFFF.
  - in_valid held high during the busy cycles is ignored.
- mul edge cases: A=0xFFFFFFFF, B=0xFFFFFFFF -> result=1. A=12345, B=0 -> result=0, Zero=1.
- flush at cycle t+10 of a mul -> no out_valid, in_ready=1 at t+11, result keeps its prior value. An add of 2+3 accepted at t+11 -> out_valid at t+12, result=5.
- reset asserted mid-MUL -> the next cycle shows all reset values, and there is no out_valid at t+33. Unknown code 0011 with A=B=9 -> result=0, Zero=1, latency 1.
